// File: rtl/nic_seq_pkg.sv
// NIC CPU-port register map, status bit index and sequencer state encoding.
package nic_seq_pkg;

    localparam logic [1:0] NIC_ADDR_IN_BUF   = 2'd0;
    localparam logic [1:0] NIC_ADDR_IN_STAT  = 2'd1;
    localparam logic [1:0] NIC_ADDR_OUT_BUF  = 2'd2;
    localparam logic [1:0] NIC_ADDR_OUT_STAT = 2'd3;

    localparam int STATUS_FULL_BIT = 0;

    localparam logic [3:0] IDLE    = 4'd0;
    localparam logic [3:0] TX_STAT = 4'd1;
    localparam logic [3:0] TX_CHK  = 4'd2;
    localparam logic [3:0] TX_WR   = 4'd3;
    localparam logic [3:0] RX_STAT = 4'd4;
    localparam logic [3:0] RX_CHK  = 4'd5;
    localparam logic [3:0] RX_RD   = 4'd6;
    localparam logic [3:0] RX_CAP  = 4'd7;
    localparam logic [3:0] RX_OUT  = 4'd8;

    localparam logic GRANT_TX = 1'b0;
    localparam logic GRANT_RX = 1'b1;

endpackage

// File: rtl/nic_cpu_sequencer.sv
// Round-robin TX/RX sequencer for a NIC CPU register port; NIC_SEQ_STATS_EN adds event counters.
// Latency: tx_ready 3 cycles after the IDLE grant; rx_valid 4 cycles after the RX status read.
// Backpressure: rx_valid holds until rx_ready and blocks all NIC traffic; a full output channel defers TX.
module nic_cpu_sequencer
    import nic_seq_pkg::*;
#(
    parameter int PACKET_WIDTH = 64,
    parameter int POLL_GAP     = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    tx_valid,
    output logic                    tx_ready,
    input  logic [PACKET_WIDTH-1:0] tx_data,
    output logic                    rx_valid,
    input  logic                    rx_ready,
    output logic [PACKET_WIDTH-1:0] rx_data,
    output logic [1:0]              nic_addr,
    output logic [PACKET_WIDTH-1:0] nic_wdata,
    input  logic [PACKET_WIDTH-1:0] nic_rdata,
    output logic                    nic_en,
    output logic                    nic_en_wr
`ifdef NIC_SEQ_STATS_EN
    ,
    output logic [15:0]             stat_tx,
    output logic [15:0]             stat_rx,
    output logic [15:0]             stat_full
`endif
);

    localparam logic [7:0] GAP = 8'(POLL_GAP);

    logic [3:0]              state_q, state_d;
    logic [7:0]              poll_cnt_q, poll_cnt_d;
    logic                    last_grant_q, last_grant_d;
    logic [PACKET_WIDTH-1:0] rx_data_q, rx_data_d;

    logic rx_due;
    logic in_rx;
    logic status_full;

    assign rx_due      = (poll_cnt_q == GAP);
    assign in_rx       = state_q inside {RX_STAT, RX_CHK, RX_RD, RX_CAP, RX_OUT};
    assign status_full = nic_rdata[STATUS_FULL_BIT];

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        rx_data_d    = rx_data_q;
        poll_cnt_d   = poll_cnt_q;
        if (!in_rx && !rx_due) begin
            poll_cnt_d = poll_cnt_q + 8'd1;
        end
        case (state_q)
            IDLE: begin
                // On a tie the side that did not win last time goes first.
                if (tx_valid && (!rx_due || last_grant_q == GRANT_RX)) begin
                    state_d      = TX_STAT;
                    last_grant_d = GRANT_TX;
                end else if (rx_due) begin
                    state_d      = RX_STAT;
                    last_grant_d = GRANT_RX;
                    poll_cnt_d   = 8'd0;
                end
            end
            TX_STAT: state_d = TX_CHK;
            TX_CHK:  state_d = (status_full || !tx_valid) ? IDLE : TX_WR;
            TX_WR:   state_d = IDLE;
            RX_STAT: state_d = RX_CHK;
            RX_CHK:  state_d = status_full ? RX_RD : IDLE;
            RX_RD:   state_d = RX_CAP;
            RX_CAP: begin
                rx_data_d = nic_rdata;
                state_d   = RX_OUT;
            end
            RX_OUT:  state_d = rx_ready ? IDLE : RX_OUT;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            poll_cnt_q   <= 8'd0;
            last_grant_q <= GRANT_RX;
            rx_data_q    <= '0;
        end else begin
            state_q      <= state_d;
            poll_cnt_q   <= poll_cnt_d;
            last_grant_q <= last_grant_d;
            rx_data_q    <= rx_data_d;
        end
    end

    always_comb begin
        nic_addr = NIC_ADDR_IN_BUF;
        case (state_q)
            TX_STAT: nic_addr = NIC_ADDR_OUT_STAT;
            TX_WR:   nic_addr = NIC_ADDR_OUT_BUF;
            RX_STAT: nic_addr = NIC_ADDR_IN_STAT;
            RX_RD:   nic_addr = NIC_ADDR_IN_BUF;
            default: nic_addr = NIC_ADDR_IN_BUF;
        endcase
    end

    assign nic_en    = state_q inside {TX_STAT, TX_WR, RX_STAT, RX_RD};
    assign nic_en_wr = (state_q == TX_WR);
    assign nic_wdata = (state_q == TX_WR) ? tx_data : '0;
    assign tx_ready  = (state_q == TX_WR);
    assign rx_valid  = (state_q == RX_OUT);
    assign rx_data   = rx_data_q;

`ifdef NIC_SEQ_STATS_EN
    logic [15:0] stat_tx_q, stat_rx_q, stat_full_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            stat_tx_q   <= 16'd0;
            stat_rx_q   <= 16'd0;
            stat_full_q <= 16'd0;
        end else begin
            if (state_q == TX_WR) begin
                stat_tx_q <= stat_tx_q + 16'd1;
            end
            if (state_q == RX_OUT && rx_ready) begin
                stat_rx_q <= stat_rx_q + 16'd1;
            end
            if (state_q == TX_CHK && status_full) begin
                stat_full_q <= stat_full_q + 16'd1;
            end
        end
    end

    assign stat_tx   = stat_tx_q;
    assign stat_rx   = stat_rx_q;
    assign stat_full = stat_full_q;
`endif

endmodule

// File: tb/tb_nic_cpu_sequencer.sv
// Bench for nic_cpu_sequencer: behavioural NIC models, directed scenarios plus a randomized scoreboard phase.
module tb_nic_cpu_sequencer;

    localparam int PW = 64;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Instance A (POLL_GAP=4) signals
    logic          reset, tx_valid, tx_ready, rx_valid, rx_ready, nic_en, nic_en_wr;
    logic [PW-1:0] tx_data, rx_data, nic_wdata, nic_rdata;
    logic [1:0]    nic_addr;
    // Instance B (POLL_GAP=0) signals
    logic          b_reset, b_tx_valid, b_tx_ready, b_rx_valid, b_rx_ready, b_en, b_wr;
    logic [PW-1:0] b_tx_data, b_rx_data, b_wdata, b_rdata;
    logic [1:0]    b_addr;
`ifdef NIC_SEQ_STATS_EN
    logic [15:0]   stat_tx, stat_rx, stat_full, b_stat_tx, b_stat_rx, b_stat_full;
`endif

    nic_cpu_sequencer #(.PACKET_WIDTH(PW), .POLL_GAP(4)) u_dut (
        .clk(clk), .reset(reset), .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_data(tx_data),
        .rx_valid(rx_valid), .rx_ready(rx_ready), .rx_data(rx_data), .nic_addr(nic_addr),
        .nic_wdata(nic_wdata), .nic_rdata(nic_rdata), .nic_en(nic_en), .nic_en_wr(nic_en_wr)
`ifdef NIC_SEQ_STATS_EN
        , .stat_tx(stat_tx), .stat_rx(stat_rx), .stat_full(stat_full)
`endif
    );

    nic_cpu_sequencer #(.PACKET_WIDTH(PW), .POLL_GAP(0)) u_dut_b (
        .clk(clk), .reset(b_reset), .tx_valid(b_tx_valid), .tx_ready(b_tx_ready), .tx_data(b_tx_data),
        .rx_valid(b_rx_valid), .rx_ready(b_rx_ready), .rx_data(b_rx_data), .nic_addr(b_addr),
        .nic_wdata(b_wdata), .nic_rdata(b_rdata), .nic_en(b_en), .nic_en_wr(b_wr)
`ifdef NIC_SEQ_STATS_EN
        , .stat_tx(b_stat_tx), .stat_rx(b_stat_rx), .stat_full(b_stat_full)
`endif
    );

    // NIC model A: input channel fed from in_q, output channel drained instantly unless out_full.
    logic [PW-1:0] in_q[$];
    logic [PW-1:0] wr_log[$];
    int            rd0_cnt = 0;
    logic          out_full;

    always @(posedge clk) begin
        if (nic_en && !nic_en_wr) begin
            case (nic_addr)
                2'd0: begin
                    if (rd0_cnt < in_q.size()) begin
                        nic_rdata <= in_q[rd0_cnt];
                        rd0_cnt   <= rd0_cnt + 1;
                    end else begin
                        nic_rdata <= '0;
                    end
                end
                2'd1:    nic_rdata <= {{(PW-1){1'b0}}, (rd0_cnt < in_q.size())};
                2'd3:    nic_rdata <= {{(PW-1){1'b0}}, out_full};
                default: nic_rdata <= '0;
            endcase
        end
        if (nic_en && nic_en_wr) wr_log.push_back(nic_wdata);
    end

    // NIC model B: output always empty, input always full.
    int b_rd = 0;
    always @(posedge clk) begin
        if (b_en && !b_wr) begin
            case (b_addr)
                2'd0: begin
                    b_rdata <= 64'hB000_0000_0000_0000 + 64'(b_rd);
                    b_rd    <= b_rd + 1;
                end
                2'd1:    b_rdata <= 64'd1;
                default: b_rdata <= 64'd0;
            endcase
        end
    end

    int total = 0, bad = 0;
    int cyc = 0, n_acc = 0, n_rd0 = 0, n_rd1 = 0, n_rd3 = 0;
    int tx_rdy_cnt = 0, rx_hs_cnt = 0, rx_vld_cyc = 0;
    int last_txr_cyc = 0, last_hs_cyc = 0, last_rd0_cyc = 0, rd1_cyc = 0, prev_rd1_cyc = 0, last_rd3_cyc = 0;
    logic [PW-1:0] rx_got[$];
    logic [PW-1:0] exp_wr[$];
    logic [PW-1:0] exp_rx[$];
    bit            ev[$];   // 0 = TX accepted, 1 = RX handshake (instance B)

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    // Sample at negedge, then return 1ns after the next posedge so callers drive there.
    task automatic cyc_step();
        @(negedge clk);
        cyc++;
        if (nic_en) begin
            n_acc++;
            if (!nic_en_wr) begin
                case (nic_addr)
                    2'd0: begin n_rd0++; last_rd0_cyc = cyc; prev_rd1_cyc = rd1_cyc; end
                    2'd1: begin n_rd1++; rd1_cyc = cyc; end
                    2'd3: begin n_rd3++; last_rd3_cyc = cyc; end
                    default: ;
                endcase
            end
        end
        if (tx_ready) begin tx_rdy_cnt++; last_txr_cyc = cyc; end
        if (rx_valid) rx_vld_cyc++;
        if (rx_valid && rx_ready) begin rx_hs_cnt++; last_hs_cyc = cyc; rx_got.push_back(rx_data); end
        chk("inv_txr_is_write", {63'b0, tx_ready}, {63'b0, nic_en && nic_en_wr});
        if (nic_en_wr) begin
            chk("inv_wr_addr", {62'b0, nic_addr}, 64'd2);
            chk("inv_wr_data", nic_wdata, tx_data);
        end else begin
            chk("inv_wdata_zero", nic_wdata, 64'd0);
        end
        if (rx_valid) chk("inv_rxout_no_access", {63'b0, nic_en}, 64'd0);
        if (b_tx_ready) ev.push_back(1'b0);
        if (b_rx_valid && b_rx_ready) ev.push_back(1'b1);
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_tx_ready"}, {63'b0, tx_ready}, 64'd0);
        chk({tag, "_rx_valid"}, {63'b0, rx_valid}, 64'd0);
        chk({tag, "_nic_en"}, {63'b0, nic_en}, 64'd0);
        chk({tag, "_nic_en_wr"}, {63'b0, nic_en_wr}, 64'd0);
        chk({tag, "_nic_addr"}, {62'b0, nic_addr}, 64'd0);
        chk({tag, "_nic_wdata"}, nic_wdata, 64'd0);
        chk({tag, "_rx_data"}, rx_data, 64'd0);
    endtask

    initial begin
        int c0, k, r1, r3, w, t0, a0, h0, v0;
        logic [PW-1:0] pkt;

        reset = 1'b1; tx_valid = 1'b0; tx_data = '0; rx_ready = 1'b0; out_full = 1'b0;
        b_reset = 1'b1; b_tx_valid = 1'b1; b_rx_ready = 1'b1; b_tx_data = 64'h0000_0000_0000_C0DE;

        // Test 1: TX offered from the first post-reset cycle, output channel empty.
        tx_valid = 1'b1; tx_data = 64'hA5A5_0000_0000_0001; exp_wr.push_back(tx_data);
        repeat (3) cyc_step();
        chk_reset_outputs("rst");
        reset = 1'b0;
        c0 = cyc + 1;
        k = 0;
        while (tx_rdy_cnt == 0 && k < 20) begin cyc_step(); k++; end
        tx_valid = 1'b0;
        chk("t1_timeout", {63'b0, tx_rdy_cnt != 0}, 64'd1);
        chk("t1_latency", 64'(last_txr_cyc - c0), 64'd3);
        chk("t1_rd3_cycle", 64'(last_rd3_cyc - c0), 64'd1);
        chk("t1_rd3_count", 64'(n_rd3), 64'd1);
        chk("t1_no_rx_poll", 64'(n_rd1), 64'd0);
        chk("t1_wr_count", 64'(wr_log.size()), 64'd1);
        chk("t1_wr_data", (wr_log.size() > 0) ? wr_log[0] : 64'hx, 64'hA5A5_0000_0000_0001);
        repeat (10) cyc_step();
        chk("t1_once", 64'(tx_rdy_cnt), 64'd1);

        // Test 2: output channel full, then empty.
        out_full = 1'b1;
        tx_data = {$urandom(), $urandom()}; tx_valid = 1'b1; exp_wr.push_back(tx_data);
        r1 = n_rd1; r3 = n_rd3; w = wr_log.size(); t0 = tx_rdy_cnt;
        repeat (12) cyc_step();
        chk("t2_no_write", 64'(wr_log.size() - w), 64'd0);
        chk("t2_no_txready", 64'(tx_rdy_cnt - t0), 64'd0);
        chk("t2_retries", {63'b0, (n_rd3 - r3) >= 2}, 64'd1);
        chk("t2_rx_interleave", {63'b0, (n_rd1 - r1) >= 1}, 64'd1);
`ifdef NIC_SEQ_STATS_EN
        chk("t2_stat_full", {63'b0, stat_full > 16'd0}, 64'd1);
`endif
        out_full = 1'b0;
        k = 0;
        while (tx_rdy_cnt == t0 && k < 30) begin cyc_step(); k++; end
        tx_valid = 1'b0;
        chk("t2_timeout", {63'b0, tx_rdy_cnt != t0}, 64'd1);
        chk("t2_one_write", 64'(wr_log.size() - w), 64'd1);
        chk("t2_wr_data", (wr_log.size() > 0) ? wr_log[$] : 64'hx, exp_wr[$]);

        // Test 3: one packet in the input channel, sink always ready.
        pkt = 64'h0000_00FF_DEAD_BEEF;
        in_q.push_back(pkt); exp_rx.push_back(pkt);
        rx_ready = 1'b1; h0 = rx_hs_cnt; v0 = rx_vld_cyc;
        k = 0;
        while (rx_hs_cnt == h0 && k < 40) begin cyc_step(); k++; end
        repeat (3) cyc_step();
        chk("t3_timeout", {63'b0, rx_hs_cnt != h0}, 64'd1);
        chk("t3_rx_data", (rx_got.size() > 0) ? rx_got[$] : 64'hx, 64'h0000_00FF_DEAD_BEEF);
        chk("t3_rx_valid_cycles", 64'(rx_vld_cyc - v0), 64'd1);
        chk("t3_rd0_to_out", 64'(last_hs_cyc - last_rd0_cyc), 64'd2);
        chk("t3_rd1_to_rd0", 64'(last_rd0_cyc - prev_rd1_cyc), 64'd2);

        // Test 4: packet held by a stalled sink while TX is pending.
        rx_ready = 1'b0;
        pkt = {$urandom(), $urandom()};
        in_q.push_back(pkt); exp_rx.push_back(pkt);
        v0 = rx_vld_cyc; k = 0;
        while (rx_vld_cyc == v0 && k < 40) begin cyc_step(); k++; end
        chk("t4_rx_timeout", {63'b0, rx_vld_cyc != v0}, 64'd1);
        tx_data = {$urandom(), $urandom()}; tx_valid = 1'b1; exp_wr.push_back(tx_data);
        a0 = n_acc; t0 = tx_rdy_cnt;
        for (int i = 0; i < 20; i++) begin
            cyc_step();
            chk("t4_rx_valid_held", {63'b0, rx_valid}, 64'd1);
            chk("t4_rx_data_stable", rx_data, pkt);
        end
        chk("t4_no_access", 64'(n_acc - a0), 64'd0);
        chk("t4_no_txready", 64'(tx_rdy_cnt - t0), 64'd0);
        rx_ready = 1'b1; k = 0;
        while (tx_rdy_cnt == t0 && k < 40) begin cyc_step(); k++; end
        tx_valid = 1'b0;
        chk("t4_tx_timeout", {63'b0, tx_rdy_cnt != t0}, 64'd1);
        chk("t4_rx_got", (rx_got.size() > 0) ? rx_got[$] : 64'hx, pkt);
        chk("t4_rx_before_tx", {63'b0, last_hs_cyc < last_txr_cyc}, 64'd1);
`ifdef NIC_SEQ_STATS_EN
        chk("t4_stat_tx", {48'b0, stat_tx}, 64'(tx_rdy_cnt));
        chk("t4_stat_rx", {48'b0, stat_rx}, 64'(rx_hs_cnt));
`endif

        // Random phase: TX packets, sporadic RX arrivals, random full status and sink stalls.
        for (int it = 0; it < 8; it++) begin
            tx_data = {$urandom(), $urandom()}; tx_valid = 1'b1; exp_wr.push_back(tx_data);
            if ($urandom_range(0, 1) == 1) begin
                pkt = {$urandom(), $urandom()};
                in_q.push_back(pkt); exp_rx.push_back(pkt);
            end
            t0 = tx_rdy_cnt; k = 0;
            while (tx_rdy_cnt == t0 && k < 300) begin
                out_full = ($urandom_range(0, 3) == 0);
                rx_ready = ($urandom_range(0, 1) == 1);
                cyc_step(); k++;
            end
            tx_valid = 1'b0;
            chk("rnd_tx_timeout", {63'b0, tx_rdy_cnt != t0}, 64'd1);
        end
        out_full = 1'b0; rx_ready = 1'b1; k = 0;
        while (rx_hs_cnt < exp_rx.size() && k < 300) begin cyc_step(); k++; end
        repeat (5) cyc_step();
        chk("sb_wr_count", 64'(wr_log.size()), 64'(exp_wr.size()));
        for (int i = 0; i < exp_wr.size() && i < wr_log.size(); i++) chk("sb_wr_data", wr_log[i], exp_wr[i]);
        chk("sb_rx_count", 64'(rx_got.size()), 64'(exp_rx.size()));
        for (int i = 0; i < exp_rx.size() && i < rx_got.size(); i++) chk("sb_rx_data", rx_got[i], exp_rx[i]);

        // Test 6: reset while the read data is being captured; the packet is discarded.
        rx_ready = 1'b1;
        pkt = {$urandom(), $urandom()};
        in_q.push_back(pkt);
        a0 = n_rd0; k = 0;
        while (n_rd0 == a0 && k < 40) begin cyc_step(); k++; end
        chk("t6_rd0_timeout", {63'b0, n_rd0 != a0}, 64'd1);
        reset = 1'b1;
        v0 = rx_vld_cyc;
        cyc_step();
        chk_reset_outputs("t6");
`ifdef NIC_SEQ_STATS_EN
        chk("t6_stat_tx", {48'b0, stat_tx}, 64'd0);
        chk("t6_stat_rx", {48'b0, stat_rx}, 64'd0);
        chk("t6_stat_full", {48'b0, stat_full}, 64'd0);
`endif
        reset = 1'b0;
        repeat (30) cyc_step();
        chk("t6_no_rx_valid", 64'(rx_vld_cyc - v0), 64'd0);

        // Test 5: POLL_GAP=0, TX always pending, input always full -> strict alternation.
        b_reset = 1'b0; k = 0;
        while (ev.size() < 16 && k < 400) begin cyc_step(); k++; end
        chk("t5_timeout", {63'b0, ev.size() >= 16}, 64'd1);
        for (int i = 0; i < 16 && i < ev.size(); i++) chk("t5_order", {63'b0, ev[i]}, 64'(i % 2));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
